instruction_fetcher: RTL

Front-end stage directly upstream of `reorder_buffer`: fetches 32-bit RV32I instructions from the instruction memory port and buffers them in a small queue. It launches one instruction per cycle into the ROB while `rob_full` is low, and redirects the PC for JAL, predicted branches, committed JALR and predictor flushes.

---
 rtl/instruction_fetcher_pkg.sv | 34 +++
 rtl/instruction_fetcher_ins_queue.sv | 58 +++++
 rtl/instruction_fetcher.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/instruction_fetcher_pkg.sv
// Shared definitions for the fetch front end: RV32I opcodes, fetch FSM encoding,
// instruction-queue entry layout and J/B immediate decoders.
package instruction_fetcher_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DISCARD,
        ST_JALR_STALL
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        pred;
    } iq_entry_t;

    function automatic logic [31:0] j_imm(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/instruction_fetcher_ins_queue.sv
// Small circular FIFO of fetched instructions {ins, pc, pred}; clear wins over push/pop.
module ins_queue
    import instruction_fetcher_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  iq_entry_t                push_data,
    input  logic                     pop,
    input  logic                     clear,
    output iq_entry_t                head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    iq_entry_t          mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    // Storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;

endmodule

// File: rtl/instruction_fetcher.sv
// RV32I fetch stage: one outstanding memory request, static redirect for JAL and
// predicted branches, stall on JALR until commit, queued launch into the ROB.
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int          IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic [31:0] br_query_pc,
    input  logic        br_predict_taken,
    input  logic        rob_full,
    output logic        if_ins_launch_flag,
    output logic [31:0] if_ins,
    output logic [31:0] if_ins_pc,
    output logic        if_ins_pred_taken,
    input  logic        rob_flush,
    input  logic [31:0] flush_pc,
    input  logic        commit_flag,
    input  logic        commit_is_jalr,
    input  logic [31:0] commit_value
);
    localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

    fetch_state_t     state_reg;
    logic [31:0]      pc_reg;
    logic             mem_req_reg;
    logic [31:0]      mem_addr_reg;
    logic             launch_flag_reg;
    logic [31:0]      ins_reg;
    logic [31:0]      ins_pc_reg;
    logic             pred_reg;

    logic [6:0]       opcode;
    logic             pred_taken;
    logic [31:0]      pc_next;
    logic             q_push;
    logic             q_pop;
    logic             q_clear;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;
    iq_entry_t        q_in;
    iq_entry_t        q_head;
    logic             can_fetch;

    assign opcode      = mem_data[6:0];
    assign pred_taken  = (opcode == OPC_BRANCH) && br_predict_taken;
    assign br_query_pc = pc_reg;

    always_comb begin
        pc_next = pc_reg + 32'd4;
        case (opcode)
            OPC_JAL:    pc_next = pc_reg + j_imm(mem_data);
            OPC_BRANCH: pc_next = br_predict_taken ? pc_reg + b_imm(mem_data) : pc_reg + 32'd4;
            OPC_JALR:   pc_next = pc_reg;
            OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC: pc_next = pc_reg + 32'd4;
            default:    pc_next = pc_reg + 32'd4;
        endcase
    end

    // Only one request is ever outstanding, so a non-full queue always has room for it.
    assign can_fetch = (q_count < CNT_W'(IQ_DEPTH));
    assign q_in      = '{ins: mem_data, pc: pc_reg, pred: pred_taken};
    assign q_clear   = rdy && rob_flush;
    assign q_push    = rdy && !rob_flush && (state_reg == ST_WAIT) && mem_done && !q_full;
    assign q_pop     = rdy && !rob_flush && !q_empty && !rob_full;

    ins_queue #(
        .DEPTH(IQ_DEPTH)
    ) u_ins_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_data(q_in),
        .pop      (q_pop),
        .clear    (q_clear),
        .head_data(q_head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC;
            mem_req_reg     <= 1'b0;
            mem_addr_reg    <= '0;
            launch_flag_reg <= 1'b0;
            ins_reg         <= '0;
            ins_pc_reg      <= '0;
            pred_reg        <= 1'b0;
        end else if (rdy) begin
            launch_flag_reg <= q_pop;
            if (q_pop) begin
                ins_reg    <= q_head.ins;
                ins_pc_reg <= q_head.pc;
                pred_reg   <= q_head.pred;
            end
            if (rob_flush) begin
                pc_reg <= flush_pc;
                // An in-flight request must still be completed by memory; swallow its data.
                if ((state_reg == ST_WAIT || state_reg == ST_DISCARD) && !mem_done) begin
                    state_reg <= ST_DISCARD;
                end else begin
                    state_reg   <= ST_IDLE;
                    mem_req_reg <= 1'b0;
                end
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (can_fetch) begin
                            mem_req_reg  <= 1'b1;
                            mem_addr_reg <= pc_reg;
                            state_reg    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (mem_done) begin
                            mem_req_reg <= 1'b0;
                            if (opcode == OPC_JALR) begin
                                state_reg <= ST_JALR_STALL;
                            end else begin
                                pc_reg    <= pc_next;
                                state_reg <= ST_IDLE;
                            end
                        end
                    end
                    ST_DISCARD: begin
                        if (mem_done) begin
                            mem_req_reg <= 1'b0;
                            state_reg   <= ST_IDLE;
                        end
                    end
                    ST_JALR_STALL: begin
                        if (commit_flag && commit_is_jalr) begin
                            pc_reg    <= commit_value;
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign mem_req            = mem_req_reg;
    assign mem_addr           = mem_addr_reg;
    assign if_ins_launch_flag = launch_flag_reg;
    assign if_ins             = ins_reg;
    assign if_ins_pc          = ins_pc_reg;
    assign if_ins_pred_taken  = pred_reg;

endmodule
